// File: rtl/seq_count_checker.sv
// seq_count_checker: observer for an incrementing counter stream, gives a pass/fail verdict after EXPECT_COUNT samples
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   start, abort            begin a run (IDLE/DONE), cancel a run or verdict
//   in_valid, in_value      sample stream from the producer
//   in_ready                high in CHECK only (state-decoded)
//   busy, done, pass, fail  run status and verdict (registered)
//   err_count, sample_count mismatches (saturating) and accepted samples of the current run
//   first_bad, expected     first mismatching value, next expected value
module seq_count_checker #(
    parameter int WIDTH        = 4,
    parameter int START_VALUE  = 0,
    parameter int EXPECT_COUNT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_value,
    output logic             in_ready,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic [7:0]       err_count,
    output logic [15:0]      sample_count,
    output logic [WIDTH-1:0] first_bad,
    output logic [WIDTH-1:0] expected
);
    localparam logic [WIDTH-1:0] START_V = WIDTH'(START_VALUE);
    localparam logic [15:0]      COUNT_V = 16'(EXPECT_COUNT);

    typedef enum logic [1:0] {IDLE, CHECK, DONE} state_t;

    state_t      state_q;
    logic        hit;
    logic        clean;
    logic        last;
    logic [7:0]  err_d;
    logic [15:0] cnt_d;

    assign in_ready = state_q == CHECK;

    always_comb begin
        hit   = in_value == expected;
        clean = hit && err_count == 8'd0;
        err_d = (hit || err_count == 8'hFF) ? err_count : err_count + 8'd1;
        cnt_d = sample_count + 16'd1;
        last  = cnt_d == COUNT_V;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            fail         <= 1'b0;
            err_count    <= 8'd0;
            sample_count <= 16'd0;
            first_bad    <= '0;
            expected     <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (abort) begin
                        state_q <= IDLE;
                        done    <= 1'b0;
                        pass    <= 1'b0;
                        fail    <= 1'b0;
                    end else if (start) begin
                        state_q      <= CHECK;
                        busy         <= 1'b1;
                        done         <= 1'b0;
                        pass         <= 1'b0;
                        fail         <= 1'b0;
                        err_count    <= 8'd0;
                        sample_count <= 16'd0;
                        first_bad    <= '0;
                        expected     <= START_V;
                    end
                end
                CHECK: begin
                    if (abort) begin
                        state_q <= IDLE;
                        busy    <= 1'b0;
                        pass    <= 1'b0;
                        fail    <= 1'b0;
                    end else if (in_valid) begin
                        sample_count <= cnt_d;
                        err_count    <= err_d;
                        // a match also yields in_value+1, so one assignment covers match and resync
                        expected     <= in_value + 1'b1;
                        if (!hit && err_count == 8'd0)
                            first_bad <= in_value;
                        if (last) begin
                            state_q <= DONE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            pass    <= clean;
                            fail    <= !clean;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_count_checker.sv
// tb_seq_count_checker: three checker configurations sharing one stimulus stream, compared every cycle with a run-log model
module tb_seq_count_checker;
    localparam int SV[3] = '{1, 14, 1};
    localparam int EC[3] = '{4, 4, 300};

    logic       clk = 1'b0;
    logic       rst_n, start, abort, in_valid;
    logic [3:0] in_value;
    logic       rdy[3], bsy[3], dn[3], ps[3], fl[3];
    logic [7:0] ecnt[3];
    logic [15:0] scnt[3];
    logic [3:0] fb[3], ex[3];

    int         ms[3];
    logic [3:0] mq[3][300];
    int         mn[3];
    logic [3:0] mb[3];
    int         vectors = 0;
    int         miscompares = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        seq_count_checker #(.WIDTH(4), .START_VALUE(SV[g]), .EXPECT_COUNT(EC[g])) u_dut (
            .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
            .in_valid(in_valid), .in_value(in_value), .in_ready(rdy[g]),
            .busy(bsy[g]), .done(dn[g]), .pass(ps[g]), .fail(fl[g]),
            .err_count(ecnt[g]), .sample_count(scnt[g]), .first_bad(fb[g]), .expected(ex[g])
        );
    end

    task automatic check(input string tag, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s got %0d exp %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // run state: 0 idle, 1 checking, 2 verdict; the run itself is just the log of accepted values
    task automatic step_model();
        for (int k = 0; k < 3; k++) begin
            if (!rst_n) begin
                ms[k] = 0; mn[k] = 0; mb[k] = 4'd0;
            end else if (ms[k] == 1) begin
                if (abort) ms[k] = 0;
                else if (in_valid) begin
                    mq[k][mn[k]] = in_value;
                    mn[k]++;
                    if (mn[k] == EC[k]) ms[k] = 2;
                end
            end else if (abort) ms[k] = 0;
            else if (start) begin
                ms[k] = 1; mn[k] = 0; mb[k] = 4'(SV[k]);
            end
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 3; k++) begin
            int err = 0;
            int first = 0;
            logic [3:0] want = mb[k];
            for (int i = 0; i < mn[k]; i++) begin
                if (mq[k][i] != want) begin
                    if (err == 0) first = int'(mq[k][i]);
                    err++;
                end
                want = 4'(mq[k][i] + 1);
            end
            check($sformatf("u%0d_in_ready", k), int'(rdy[k]), int'(ms[k] == 1));
            check($sformatf("u%0d_busy", k), int'(bsy[k]), int'(ms[k] == 1));
            check($sformatf("u%0d_done", k), int'(dn[k]), int'(ms[k] == 2));
            check($sformatf("u%0d_pass", k), int'(ps[k]), int'(ms[k] == 2 && err == 0));
            check($sformatf("u%0d_fail", k), int'(fl[k]), int'(ms[k] == 2 && err != 0));
            check($sformatf("u%0d_err_count", k), int'(ecnt[k]), err > 255 ? 255 : err);
            check($sformatf("u%0d_sample_count", k), int'(scnt[k]), mn[k]);
            check($sformatf("u%0d_first_bad", k), int'(fb[k]), first);
            check($sformatf("u%0d_expected", k), int'(ex[k]), int'(want));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        step_model();
        #1;
        check_all();
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic feed(input int v);
        in_valid = 1'b1; in_value = 4'(v); tick(); in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; tick(); rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0] cnt = 4'd0;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_value = 4'd0;
        tick();
        check("reset_done", int'(dn[0]), 0);
        check("reset_expected", int'(ex[1]), 0);
        rst_n = 1'b1;
        in_valid = 1'b1; in_value = 4'd5; tick(); tick(); in_valid = 1'b0;
        check("idle_bp_count", int'(scnt[0]), 0);

        pulse_start();
        for (int i = 1; i <= 4; i++) feed(i);
        check("t1_pass", int'(ps[0]), 1);
        check("t1_fail", int'(fl[0]), 0);
        check("t1_expected", int'(ex[0]), 5);
        in_valid = 1'b1; in_value = 4'd4; tick(); tick(); in_valid = 1'b0;
        check("done_bp_count", int'(scnt[0]), 4);

        pulse_start();
        feed(1); feed(2); feed(7); feed(8);
        check("t2_fail", int'(fl[0]), 1);
        check("t2_err", int'(ecnt[0]), 1);
        check("t2_first_bad", int'(fb[0]), 7);
        check("t2_expected", int'(ex[0]), 9);

        pulse_start();
        check("restart_first_bad", int'(fb[0]), 0);
        for (int i = 1; i <= 4; i++) feed(i);
        check("restart_pass", int'(ps[0]), 1);

        pulse_start();
        feed(14); feed(15); feed(0); feed(1);
        check("wrap_pass", int'(ps[1]), 1);
        check("wrap_expected", int'(ex[1]), 2);

        pulse_start();
        feed(1); tick(); feed(2); tick(); feed(3); feed(4);
        check("gap_pass", int'(ps[0]), 1);

        pulse_start();
        feed(1); feed(2);
        do_reset();
        check("midrun_reset_count", int'(scnt[0]), 0);

        start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
        check("start_abort_idle", int'(bsy[0]), 0);

        pulse_start();
        feed(1); feed(2);
        abort = 1'b1; tick(); abort = 1'b0;
        check("abort_count", int'(scnt[0]), 2);
        check("abort_busy", int'(bsy[0]), 0);

        do_reset();
        pulse_start();
        for (int i = 0; i < 300; i++) feed(0);
        check("sat_err", int'(ecnt[2]), 255);
        check("sat_fail", int'(fl[2]), 1);

        for (int i = 0; i < 600; i++) begin
            rst_n    = $urandom_range(0, 59) != 0;
            start    = $urandom_range(0, 5) == 0;
            abort    = $urandom_range(0, 19) == 0;
            in_valid = $urandom_range(0, 3) != 0;
            in_value = $urandom_range(0, 7) == 0 ? 4'($urandom) : cnt;
            if (in_valid) cnt = in_value + 4'd1;
            tick();
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
